// File: rtl/hba_pkg.sv
// Shared HBA bus definitions: default widths, arbiter state encoding and
// the maximum number of bus masters an arbiter may serve.
package hba_pkg;

  localparam int HBA_DBUS_WIDTH        = 8;
  localparam int HBA_PERIPH_ADDR_WIDTH = 4;
  localparam int HBA_REG_ADDR_WIDTH    = 8;
  localparam int HBA_ADDR_WIDTH        = HBA_PERIPH_ADDR_WIDTH + HBA_REG_ADDR_WIDTH;
  localparam int HBA_MAX_MASTERS       = 8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  // Width of a master index; never narrower than one bit.
  function automatic int hba_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hba_rr_picker.sv
// Round-robin winner selection: searches upward from ptr+1, wrapping modulo
// NUM_MASTERS; the first asserted request wins. Purely combinational.
module hba_rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] win_oh,
  output logic [PTR_W-1:0]       win_idx,
  output logic                   any_req
);

  localparam int unsigned NM = NUM_MASTERS;

  logic             found;
  logic [PTR_W-1:0] cand;

  // Rotating priority search starting just above the last owner
  always_comb begin
    win_oh  = '0;
    win_idx = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NM);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    if (found) begin
      win_oh[win_idx] = 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/hba_arbiter_rr.sv
// Round-robin HBA bus arbiter with grant-gated master-to-slave bus mux.
// Guarantees idle bus cycles between owners (RELEASE then IDLE).
// Optional select-without-xferack timeout: define HBA_ARB_TIMEOUT_EN.
module hba_arbiter_rr
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DBUS_WIDTH     = HBA_DBUS_WIDTH,
  parameter int ADDR_WIDTH     = HBA_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              hba_clk,
  input  logic                              hba_reset_n,
  input  logic [NUM_MASTERS-1:0]            hba_mrequest,
  output logic [NUM_MASTERS-1:0]            hba_mgrant,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] hba_abus_m,
  input  logic [NUM_MASTERS-1:0]            hba_rnw_m,
  input  logic [NUM_MASTERS-1:0]            hba_select_m,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] hba_dbus_m,
  input  logic                              hba_xferack,
  output logic [ADDR_WIDTH-1:0]             hba_abus,
  output logic                              hba_rnw,
  output logic                              hba_select,
  output logic [DBUS_WIDTH-1:0]             hba_dbus_wr,
  output logic                              hba_arb_err
);

  localparam int          PTR_W = hba_ptr_width(NUM_MASTERS);
  localparam int unsigned NM    = NUM_MASTERS;

  if (NUM_MASTERS < 2 || NUM_MASTERS > HBA_MAX_MASTERS) begin : g_bad_cfg
    $error("hba_arbiter_rr: NUM_MASTERS out of range");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [PTR_W-1:0]       pick_idx;
  logic                   any_req;
  logic                   owner_req;
  logic                   timeout_hit;

  hba_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .PTR_W      (PTR_W)
  ) u_picker (
    .req    (hba_mrequest),
    .ptr    (ptr_q),
    .win_oh (pick_oh),
    .win_idx(pick_idx),
    .any_req(any_req)
  );

  assign owner_req = |(hba_mrequest & grant_q);

  // State, grant and last-owner pointer registers
  always_ff @(posedge hba_clk) begin
    if (!hba_reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: grant from IDLE, hold while owner requests, one RELEASE cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = pick_oh;
          ptr_d   = pick_idx;
          state_d = ARB_GRANTED;
        end
      end
      ARB_GRANTED: begin
        // A timed-out owner keeps the pointer, so it becomes lowest priority
        if (!owner_req || timeout_hit) begin
          grant_d = '0;
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Outputs: registered grant, bus fields OR-ed over grant-gated masters
  always_comb begin
    hba_mgrant  = grant_q;
    hba_abus    = '0;
    hba_dbus_wr = '0;
    hba_rnw     = 1'b0;
    hba_select  = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      hba_abus    = hba_abus | (hba_abus_m[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
      hba_dbus_wr = hba_dbus_wr | (hba_dbus_m[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{grant_q[i]}});
      hba_rnw     = hba_rnw | (hba_rnw_m[i] & grant_q[i]);
      hba_select  = hba_select | (hba_select_m[i] & grant_q[i]);
    end
  end

`ifdef HBA_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // Timeout counter and one-cycle error pulse
  always_ff @(posedge hba_clk) begin
    if (!hba_reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_hit;
    end
  end

  // Count granted select cycles without xferack; fire on the limit
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if (state_q == ARB_GRANTED && !hba_xferack) begin
      if (hba_select) begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  assign hba_arb_err = err_q;
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign hba_arb_err = 1'b0;
  assign unused_cfg  = hba_xferack ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_hba_arbiter_rr.sv
// Directed testbench for hba_arbiter_rr (4 masters). A behavioural model
// produces the expected grant/bus/error each cycle; expectations are queued
// on drive and popped/compared one cycle later. HBA_ARB_TIMEOUT_EN selects
// the timeout scenario variant.
module tb_hba_arbiter_rr;

  localparam int NM = 4;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct {
    logic [NM-1:0] gnt;
    logic [AW-1:0] abus;
    logic [DW-1:0] dbus;
    logic          rnw;
    logic          sel;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NM-1:0]    req, rnw_m, sel_m;
  logic [AW-1:0]    abus_m [NM];
  logic [DW-1:0]    dbus_m [NM];
  logic             ack;
  logic [NM*AW-1:0] abus_flat;
  logic [NM*DW-1:0] dbus_flat;

  logic [NM-1:0] mgrant;
  logic [AW-1:0] abus;
  logic          rnw, sel, arb_err;
  logic [DW-1:0] dbus_wr;

  always_comb begin
    abus_flat = '0;
    dbus_flat = '0;
    for (int i = 0; i < NM; i++) begin
      abus_flat[i*AW +: AW] = abus_m[i];
      dbus_flat[i*DW +: DW] = dbus_m[i];
    end
  end

  hba_arbiter_rr #(
    .NUM_MASTERS   (NM),
    .DBUS_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .hba_clk     (clk),
    .hba_reset_n (rst_n),
    .hba_mrequest(req),
    .hba_mgrant  (mgrant),
    .hba_abus_m  (abus_flat),
    .hba_rnw_m   (rnw_m),
    .hba_select_m(sel_m),
    .hba_dbus_m  (dbus_flat),
    .hba_xferack (ack),
    .hba_abus    (abus),
    .hba_rnw     (rnw),
    .hba_select  (sel),
    .hba_dbus_wr (dbus_wr),
    .hba_arb_err (arb_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t sbq[$];

  // model state: 0 idle, 1 granted, 2 release
  int            m_st  = 0;
  int            m_ptr = NM - 1;
  int            m_cnt = 0;
  logic [NM-1:0] m_gnt = '0;
  logic          m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance the reference model across one clock edge using current inputs
  task automatic model_edge();
    logic fire;
    logic owner_sel;
    fire = 1'b0;
    owner_sel = |(sel_m & m_gnt);
    if (!rst_n) begin
      m_st = 0; m_gnt = '0; m_ptr = NM - 1; m_cnt = 0; m_err = 1'b0;
      return;
    end
    if (m_st == 0) begin
      if (req != '0) begin
        for (int k = 1; k <= NM; k++) begin
          int w;
          w = (m_ptr + k) % NM;
          if (req[w]) begin
            m_gnt = '0;
            m_gnt[w] = 1'b1;
            m_ptr = w;
            m_st = 1;
            m_cnt = 0;
            break;
          end
        end
      end
    end else if (m_st == 1) begin
      if ((req & m_gnt) == '0) begin
        m_gnt = '0; m_st = 2; m_cnt = 0;
      end else begin
`ifdef HBA_ARB_TIMEOUT_EN
        if (ack) m_cnt = 0;
        else if (owner_sel) begin
          if (m_cnt == TO - 1) begin
            fire = 1'b1; m_gnt = '0; m_st = 2; m_cnt = 0;
          end else m_cnt++;
        end
`endif
      end
    end else begin
      m_st = 0; m_gnt = '0;
    end
    m_err = fire;
  endtask

  task automatic step(input string tag);
    exp_t e, o;
    model_edge();
    e.gnt = m_gnt; e.abus = '0; e.dbus = '0; e.rnw = 1'b0; e.sel = 1'b0; e.err = m_err;
    for (int i = 0; i < NM; i++) begin
      if (m_gnt[i]) begin
        e.abus = abus_m[i]; e.dbus = dbus_m[i]; e.rnw = rnw_m[i]; e.sel = sel_m[i];
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    o = sbq.pop_front();
    chk({tag, ".grant"}, 32'(mgrant), 32'(o.gnt));
    chk({tag, ".abus"}, 32'(abus), 32'(o.abus));
    chk({tag, ".dbus"}, 32'(dbus_wr), 32'(o.dbus));
    chk({tag, ".rnw"}, 32'(rnw), 32'(o.rnw));
    chk({tag, ".select"}, 32'(sel), 32'(o.sel));
    chk({tag, ".err"}, 32'(arb_err), 32'(o.err));
  endtask

  int owners[$];

  // Owners hold for `hold` granted cycles, drop, then re-request during release
  task automatic run_hold(input string tag, input int cycles, input int hold, input logic [NM-1:0] mask);
    int held = 0;
    int last = -1;
    req = mask;
    for (int c = 0; c < cycles; c++) begin
      if (m_gnt != '0) begin
        held++;
        if (held >= hold) req = req & ~m_gnt;
      end else begin
        held = 0;
        req = mask;
      end
      step(tag);
      for (int i = 0; i < NM; i++) begin
        if (mgrant[i] && i != last) begin
          owners.push_back(i);
          last = i;
        end
      end
      if (mgrant == '0) last = -1;
    end
  endtask

  initial begin
    int err_pulses;
    int err_at;
    int exp_order [4];
    exp_order = '{1, 3, 0, 1};

    rst_n = 1'b0; req = '1; rnw_m = '0; sel_m = '1; ack = 1'b0;
    for (int i = 0; i < NM; i++) begin
      abus_m[i] = 12'hABC; dbus_m[i] = 8'h5A;
    end

    // reset with all requests high
    repeat (3) step("reset");
    rst_n = 1'b1; req = '0; sel_m = '0;
    for (int i = 0; i < NM; i++) begin
      abus_m[i] = '0; dbus_m[i] = '0;
    end
    repeat (2) step("idle");

    // single master 0 transfer with ack
    req[0] = 1'b1; abus_m[0] = 12'h100; dbus_m[0] = 8'h01; sel_m[0] = 1'b1;
    repeat (3) step("single");
    ack = 1'b1;
    step("single_ack");
    ack = 1'b0; sel_m[0] = 1'b0; req[0] = 1'b0;
    repeat (3) step("single_drop");

    // isolation: ungranted master 1 drives junk onto its port
    abus_m[1] = 12'hFFF; sel_m[1] = 1'b1; rnw_m[1] = 1'b1; dbus_m[1] = 8'hFF;
    req[0] = 1'b1; abus_m[0] = 12'h200; dbus_m[0] = 8'h22; sel_m[0] = 1'b1;
    repeat (4) step("isolate");
    chk("isolate.abus_owner", 32'(abus), 32'h200);
    req = '0; sel_m = '0; rnw_m = '0;
    repeat (3) step("isolate_drop");

    // contention between masters 0 and 1, hold 4 cycles each
    sel_m = 2'b11; abus_m[1] = 12'h311; dbus_m[1] = 8'h31;
    run_hold("contend", 30, 4, 4'b0011);
    req = '0; sel_m = '0;
    repeat (3) step("contend_drop");

    // make master 0 the last owner, then fairness with requests 1011
    req[0] = 1'b1;
    repeat (2) step("prime");
    req = '0;
    repeat (3) step("prime_drop");
    rnw_m = 4'b1010; sel_m = 4'b1011;
    abus_m[3] = 12'h433; dbus_m[3] = 8'h43;
    owners.delete();
    run_hold("fair", 18, 2, 4'b1011);
    for (int n = 0; n < 4; n++) begin
      if (owners.size() > n) chk($sformatf("fair.order%0d", n), 32'(owners[n]), 32'(exp_order[n]));
      else chk($sformatf("fair.order%0d_missing", n), 32'(owners.size()), 32'(n + 1));
    end
    req = '0; sel_m = '0; rnw_m = '0;
    repeat (3) step("fair_drop");

    // reset mid-transfer
    req[2] = 1'b1; sel_m[2] = 1'b1; abus_m[2] = 12'h522; dbus_m[2] = 8'h52;
    repeat (3) step("midxfer");
    rst_n = 1'b0;
    step("midxfer_reset");
    rst_n = 1'b1; req = '0; sel_m = '0;
    repeat (2) step("post_reset");

    // select without xferack: master 2 owns, master 3 waits
    err_pulses = 0; err_at = -1;
    req = 4'b1100; sel_m = 4'b0100;
    for (int c = 1; c <= 24; c++) begin
      step("stall");
      if (arb_err) begin
        err_pulses++;
        if (err_at < 0) err_at = c;
      end
    end
`ifdef HBA_ARB_TIMEOUT_EN
    chk("timeout.pulses", 32'(err_pulses), 32'd1);
    chk("timeout.cycle", 32'(err_at), 32'(TO + 1));
`else
    chk("noto.pulses", 32'(err_pulses), 32'd0);
    chk("noto.grant_held", 32'(mgrant), 32'b0100);
`endif
    req = '0; sel_m = '0;
    repeat (3) step("end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
